// File: rtl/mips_mem_arb_pkg.sv
// Shared types and constants for the MIPS data-memory arbiter.
package mips_mem_arb_pkg;

   localparam int DEF_ADDR_W = 32;
   localparam int DEF_DATA_W = 32;
   localparam int CNT_W      = 4;

   localparam logic PORT_A = 1'b0;
   localparam logic PORT_B = 1'b1;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } state_t;

endpackage

// File: rtl/rr_arbiter_2.sv
// Two-requester round-robin pick; purely combinational.
// On a tie the port that did not win last time is chosen.
module rr_arbiter_2
   import mips_mem_arb_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last_grant,
   output logic       grant_vld,
   output logic       grant
);

   always_comb begin
      grant_vld = |req;
      grant     = PORT_A;
      if (req == 2'b11) begin
         grant = ~last_grant;
      end else if (req[PORT_B]) begin
         grant = PORT_B;
      end
   end

endmodule

// File: rtl/mips_data_mem_arbiter.sv
// Round-robin sharing of one data memory between core (A) and loader (B) ports.
// Done pulses ACCESS_CYCLES+1 cycles after the granting edge; losers wait with req held.
module mips_data_mem_arbiter
   import mips_mem_arb_pkg::*;
#(
   parameter int ADDR_W        = DEF_ADDR_W,
   parameter int DATA_W        = DEF_DATA_W,
   parameter int ACCESS_CYCLES = 1
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              a_req,
   input  logic              a_we,
   input  logic [ADDR_W-1:0] a_addr,
   input  logic [DATA_W-1:0] a_wdata,
   output logic              a_done,
   output logic [DATA_W-1:0] a_rdata,
   input  logic              b_req,
   input  logic              b_we,
   input  logic [ADDR_W-1:0] b_addr,
   input  logic [DATA_W-1:0] b_wdata,
   output logic              b_done,
   output logic [DATA_W-1:0] b_rdata,
   output logic [ADDR_W-1:0] mem_address,
   output logic [DATA_W-1:0] write_data,
   output logic              mem_read,
   output logic              mem_write,
   input  logic [DATA_W-1:0] read_data,
   output logic              busy
);

   state_t             state, state_nxt;
   logic [CNT_W-1:0]   cnt, cnt_nxt;
   logic               win;
   logic               last_grant;
   logic               grant_vld;
   logic               grant;
   logic               sel_we;
   logic [ADDR_W-1:0]  sel_addr;
   logic [DATA_W-1:0]  sel_wdata;

   rr_arbiter_2 u_arb (
      .req        ({b_req, a_req}),
      .last_grant (last_grant),
      .grant_vld  (grant_vld),
      .grant      (grant)
   );

   always_comb begin
      sel_we    = a_we;
      sel_addr  = a_addr;
      sel_wdata = a_wdata;
      if (grant == PORT_B) begin
         sel_we    = b_we;
         sel_addr  = b_addr;
         sel_wdata = b_wdata;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
         cnt   <= '0;
      end else begin
         state <= state_nxt;
         cnt   <= cnt_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      cnt_nxt   = cnt;
      case (state)
         IDLE: begin
            if (grant_vld) begin
               state_nxt = ACCESS;
               cnt_nxt   = CNT_W'(ACCESS_CYCLES - 1);
            end
         end
         ACCESS: begin
            if (cnt == '0) begin
               state_nxt = DONE;
            end else begin
               cnt_nxt = cnt - 1'b1;
            end
         end
         DONE:    state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // mem_address/write_data double as the latched request; mem_read marks a read in flight.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         win         <= PORT_A;
         last_grant  <= PORT_B;
         mem_address <= '0;
         write_data  <= '0;
         mem_read    <= 1'b0;
         mem_write   <= 1'b0;
         a_done      <= 1'b0;
         b_done      <= 1'b0;
         a_rdata     <= '0;
         b_rdata     <= '0;
         busy        <= 1'b0;
      end else begin
         a_done <= (state == DONE) && (win == PORT_A);
         b_done <= (state == DONE) && (win == PORT_B);
         busy   <= (state_nxt != IDLE);
         if (state == IDLE && grant_vld) begin
            win         <= grant;
            last_grant  <= grant;
            mem_address <= sel_addr;
            write_data  <= sel_wdata;
            mem_read    <= ~sel_we;
            mem_write   <= sel_we;
         end
         if (state == ACCESS && cnt == '0) begin
            mem_read  <= 1'b0;
            mem_write <= 1'b0;
            if (mem_read) begin
               if (win == PORT_A) begin
                  a_rdata <= read_data;
               end else begin
                  b_rdata <= read_data;
               end
            end
         end
      end
   end

endmodule

// File: tb/tb_mips_data_mem_arbiter.sv
// Scoreboard bench: u_dut (1-cycle access) against a memory model, u_dut3 (3-cycle access) cycle by cycle.
module tb_mips_data_mem_arbiter;

   typedef struct packed {
      logic        port;
      logic        we;
      logic [31:0] data;
   } exp_t;

   logic clk = 1'b0;
   logic rst_n = 1'b0;
   always #5 clk = ~clk;

   logic        a_req, a_we, a_done, b_req, b_we, b_done;
   logic [31:0] a_addr, a_wdata, a_rdata, b_addr, b_wdata, b_rdata;
   logic [31:0] mem_address, write_data, read_data;
   logic        mem_read, mem_write, busy;

   logic        x_a_req, x_a_we, x_a_done, x_b_req, x_b_we, x_b_done;
   logic [31:0] x_a_addr, x_a_wdata, x_a_rdata, x_b_addr, x_b_wdata, x_b_rdata;
   logic [31:0] x_mem_address, x_write_data, x_read_data;
   logic        x_mem_read, x_mem_write, x_busy;

   logic [31:0] mem [0:63];
   logic [31:0] ref_mem [0:63];
   logic        mem_load;
   exp_t        sb_q[$];
   exp_t        mon_e;
   int          n_chk = 0;
   int          n_pass = 0;
   int          rd_n = 0;
   int          wr_n = 0;
   logic [31:0] exp_a = '0;
   logic [31:0] exp_b = '0;

   mips_data_mem_arbiter #(.ACCESS_CYCLES(1)) u_dut (
      .clk(clk), .rst_n(rst_n),
      .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata),
      .a_done(a_done), .a_rdata(a_rdata),
      .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata),
      .b_done(b_done), .b_rdata(b_rdata),
      .mem_address(mem_address), .write_data(write_data),
      .mem_read(mem_read), .mem_write(mem_write),
      .read_data(read_data), .busy(busy)
   );

   mips_data_mem_arbiter #(.ACCESS_CYCLES(3)) u_dut3 (
      .clk(clk), .rst_n(rst_n),
      .a_req(x_a_req), .a_we(x_a_we), .a_addr(x_a_addr), .a_wdata(x_a_wdata),
      .a_done(x_a_done), .a_rdata(x_a_rdata),
      .b_req(x_b_req), .b_we(x_b_we), .b_addr(x_b_addr), .b_wdata(x_b_wdata),
      .b_done(x_b_done), .b_rdata(x_b_rdata),
      .mem_address(x_mem_address), .write_data(x_write_data),
      .mem_read(x_mem_read), .mem_write(x_mem_write),
      .read_data(x_read_data), .busy(x_busy)
   );

   assign read_data   = mem[mem_address[5:0]];
   assign x_read_data = x_mem_address ^ 32'hC0DE_0000;

   always @(posedge clk) begin
      if (mem_load) begin
         for (int i = 0; i < 64; i++)
            mem[i] <= (i == 21) ? 32'hFDFF_FFFF : (32'h1000_0000 + 32'(i));
      end else if (mem_write) begin
         mem[mem_address[5:0]] <= write_data;
      end
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
   endtask

   always @(negedge clk) begin
      if (!rst_n) begin
         exp_a = '0;
         exp_b = '0;
         rd_n  = 0;
         wr_n  = 0;
      end else begin
         chk("strobe_overlap", 32'(mem_read & mem_write), 32'd0);
         if (mem_read)  rd_n++;
         if (mem_write) wr_n++;
         if (a_done || b_done) begin
            chk("done_both", 32'(a_done & b_done), 32'd0);
            if (sb_q.size() == 0) begin
               chk("done_unexpected", 32'd1, 32'd0);
            end else begin
               mon_e = sb_q.pop_front();
               chk("grant_port", 32'(b_done), 32'(mon_e.port));
               if (!mon_e.we) begin
                  if (mon_e.port) exp_b = mon_e.data;
                  else            exp_a = mon_e.data;
               end
               chk("a_rdata", a_rdata, exp_a);
               chk("b_rdata", b_rdata, exp_b);
               chk("strobe_cycles", 32'(rd_n + wr_n), 32'd1);
               chk("strobe_kind", 32'(mon_e.we ? wr_n : rd_n), 32'd1);
            end
            rd_n = 0;
            wr_n = 0;
         end
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic push(input logic port, input logic we, input logic [31:0] addr,
                       input logic [31:0] wdata);
      exp_t e;
      e.port = port;
      e.we   = we;
      e.data = we ? wdata : ref_mem[addr[5:0]];
      if (we) ref_mem[addr[5:0]] = wdata;
      sb_q.push_back(e);
   endtask

   task automatic wait_done(input logic port, input int max, output int n);
      n = 0;
      do begin
         tick();
         n++;
      end while (!(port ? b_done : a_done) && n < max);
      if (!(port ? b_done : a_done)) chk(port ? "b_done_timeout" : "a_done_timeout", 32'd0, 32'd1);
   endtask

   task automatic access1(input logic port, input logic we, input logic [31:0] addr,
                          input logic [31:0] wdata, output int lat);
      push(port, we, addr, wdata);
      if (port) begin b_req = 1'b1; b_we = we; b_addr = addr; b_wdata = wdata; end
      else      begin a_req = 1'b1; a_we = we; a_addr = addr; a_wdata = wdata; end
      wait_done(port, 40, lat);
      a_req = 1'b0;
      b_req = 1'b0;
   endtask

   task automatic x_read(input logic port, input logic [31:0] addr);
      logic        dn;
      logic [31:0] rd;
      if (port) begin x_b_req = 1'b1; x_b_we = 1'b0; x_b_addr = addr; end
      else      begin x_a_req = 1'b1; x_a_we = 1'b0; x_a_addr = addr; end
      for (int i = 1; i <= 6; i++) begin
         tick();
         dn = port ? x_b_done : x_a_done;
         rd = port ? x_b_rdata : x_a_rdata;
         chk("x_mem_read", 32'(x_mem_read), 32'(i <= 3));
         chk("x_mem_write", 32'(x_mem_write), 32'd0);
         chk("x_busy", 32'(x_busy), 32'(i <= 4));
         chk("x_done", 32'(dn), 32'(i == 5));
         if (i == 1) chk("x_mem_address", x_mem_address, addr);
         if (i == 5) begin
            chk("x_rdata", rd, addr ^ 32'hC0DE_0000);
            x_a_req = 1'b0;
            x_b_req = 1'b0;
         end
      end
   endtask

   initial begin
      int lat;
      int n;
      int dones;
      logic seen;
      a_req = 0; a_we = 0; a_addr = '0; a_wdata = '0;
      b_req = 0; b_we = 0; b_addr = '0; b_wdata = '0;
      x_a_req = 0; x_a_we = 0; x_a_addr = '0; x_a_wdata = '0;
      x_b_req = 0; x_b_we = 0; x_b_addr = '0; x_b_wdata = '0;
      for (int i = 0; i < 64; i++)
         ref_mem[i] = (i == 21) ? 32'hFDFF_FFFF : (32'h1000_0000 + 32'(i));
      mem_load = 1'b1;
      tick();
      tick();
      mem_load = 1'b0;

      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_strobes", 32'({mem_read, mem_write}), 32'd0);
      chk("rst_done", 32'({a_done, b_done}), 32'd0);
      chk("rst_mem_address", mem_address, 32'd0);
      chk("rst_write_data", write_data, 32'd0);
      chk("rst_rdata", a_rdata | b_rdata, 32'd0);
      rst_n = 1'b1;
      tick();

      access1(1'b0, 1'b0, 32'h15, 32'h0, lat);
      chk("read_a_latency", 32'(lat), 32'd3);
      access1(1'b1, 1'b1, 32'h15, 32'h1234_5678, lat);
      chk("write_b_latency", 32'(lat), 32'd3);
      chk("write_b_data", write_data, 32'h1234_5678);
      access1(1'b0, 1'b0, 32'h15, 32'h0, lat);
      tick();
      chk("sb_drain_1", 32'(sb_q.size()), 32'd0);

      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      tick();
      for (int k = 0; k < 2; k++) begin
         push(1'b0, 1'b0, 32'h2, 32'h0);
         push(1'b1, 1'b0, 32'h3, 32'h0);
      end
      a_addr = 32'h2; a_we = 1'b0; b_addr = 32'h3; b_we = 1'b0;
      a_req = 1'b1; b_req = 1'b1;
      n = 0;
      dones = 0;
      while (dones < 4 && n < 60) begin
         tick();
         n++;
         if (a_done || b_done) dones++;
      end
      a_req = 1'b0; b_req = 1'b0;
      chk("tie_dones", 32'(dones), 32'd4);
      chk("tie_cycles", 32'(n), 32'd12);
      tick();
      tick();
      chk("sb_drain_2", 32'(sb_q.size()), 32'd0);
      chk("tie_idle_busy", 32'(busy), 32'd0);

      push(1'b0, 1'b0, 32'h15, 32'h0);
      push(1'b1, 1'b0, 32'h15, 32'h0);
      a_addr = 32'h15; b_addr = 32'h15; a_we = 1'b0; b_we = 1'b0;
      a_req = 1'b1; b_req = 1'b1;
      tick();
      a_req = 1'b0;
      wait_done(1'b1, 40, lat);
      b_req = 1'b0;
      chk("drop_b_latency", 32'(lat), 32'd5);
      tick();
      tick();
      chk("sb_drain_3", 32'(sb_q.size()), 32'd0);

      x_read(1'b0, 32'h7);

      x_b_we = 1'b1; x_b_addr = 32'h9; x_b_wdata = 32'hDEAD_BEEF; x_b_req = 1'b1;
      tick();
      chk("abort_wr_c1", 32'(x_mem_write), 32'd1);
      tick();
      chk("abort_wr_c2", 32'(x_mem_write), 32'd1);
      rst_n = 1'b0;
      #1;
      x_b_req = 1'b0;
      chk("abort_strobes", 32'({x_mem_read, x_mem_write}), 32'd0);
      chk("abort_busy", 32'(x_busy), 32'd0);
      chk("abort_mem_address", x_mem_address, 32'd0);
      chk("abort_write_data", x_write_data, 32'd0);
      chk("abort_a_rdata", x_a_rdata, 32'd0);
      chk("abort_done", 32'({x_a_done, x_b_done}), 32'd0);
      tick();
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         if (x_a_done || x_b_done) seen = 1'b1;
      end
      chk("abort_no_done", 32'(seen), 32'd0);
      x_read(1'b1, 32'h4);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
